synaptic_accumulator: RTL and testbench
=======================================

# synaptic_accumulator

Receives weighted synaptic events from the spike router's output stream and accumulates them into a per-neuron signed input-current buffer. On each timestep tick it drains every neuron's accumulated current, in neuron-ID order, to the neuron array and clears the buffer for the next timestep. It sits between the spike router (upstream) and the LIF neuron array (downstream).

## Interface
- NUM_NEURONS, 64, number of target neurons and accumulator entries.
- NEURON_ID_WIDTH, 6, width of neuron IDs; must satisfy 2^NEURON_ID_WIDTH >= NUM_NEURONS.
- WEIGHT_WIDTH, 8, width of the unsigned synaptic weight.
- ACC_WIDTH, 16, width of the signed two's-complement accumulator.

Ports:
- clk  in  1  sole clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_syn_valid  in  1  synaptic event valid.
- s_syn_dest_id  in  NEURON_ID_WIDTH  target neuron.
- s_syn_weight  in  WEIGHT_WIDTH  unsigned weight magnitude.
- s_syn_exc_inh  in  1  1 = excitatory (add), 0 = inhibitory (subtract).
- s_syn_ready  out  1  accumulator can accept an event.
- timestep_tick  in  1  single-cycle pulse that ends the current timestep.
- m_cur_valid  out  1  drained current valid.
- m_cur_neuron_id  out  NEURON_ID_WIDTH  neuron ID of the drained entry.
- m_cur_value  out  ACC_WIDTH  signed accumulated current.
- m_cur_ready  in  1  neuron array accepts the drained entry.
- busy  out  1  high in every state except ACCUM.
- sat_count  out  16  number of saturating accumulations; saturates at 0xFFFF.
- tick_overrun  out  1  sticky; set when a tick is dropped.

## Operation
- Accumulator: NUM_NEURONS x ACC_WIDTH signed RAM.
- States: CLEAR, ACCUM, DRAIN_WAIT, DRAIN.
- **CLEAR:** entered on reset. Writes zero to one entry per cycle, 0 to NUM_NEURONS-1, then moves to ACCUM.
- **ACCUM:**
  - s_syn_ready = 1 when no tick is pending.
  - An event is accepted when s_syn_valid && s_syn_ready.
  - Two-stage read-modify-write: stage 1 reads the entry; stage 2 computes the sum and writes it back.
  - Excitatory events add the weight, zero-extended. Inhibitory events subtract it.
  - The sum is computed at ACC_WIDTH+1 bits, then clamped to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - Each clamp increments sat_count.
  - Back-to-back events to the same ID forward the stage-2 result into stage 1. No event is lost and no stall is inserted. Throughput is 1 event per cycle.
- **Tick in ACCUM:**
  - Sets tick_pending. s_syn_ready is 0 from the next cycle.
  - An event accepted in the same cycle as the tick belongs to the current timestep.
  - Next state is DRAIN_WAIT.
- **DRAIN_WAIT:** waits until the RMW pipeline is empty, then enters DRAIN with index = 0.
- **DRAIN:**
  - For each index 0..NUM_NEURONS-1: read the entry, then present it on m_cur_*.
  - m_cur_valid is held until m_cur_ready.
  - On handshake, write zero to that entry and advance the index.
  - Every neuron is emitted every drain, including zero entries.
  - After the handshake for index NUM_NEURONS-1, tick_pending is cleared and the next state is ACCUM.
- **Tick outside ACCUM:** a tick in CLEAR, DRAIN_WAIT or DRAIN is dropped and sets tick_overrun. Only reset clears tick_overrun.
- **Reset mid-operation:** all state is aborted, outputs go to their reset values, and CLEAR restarts. Accumulated data is discarded.

## Timing
- **Reset values:**
  - s_syn_ready = 0, m_cur_valid = 0, m_cur_neuron_id = 0, m_cur_value = 0.
  - busy = 1 (CLEAR), sat_count = 0, tick_overrun = 0.
- **Clear:** after rst_n deasserts, s_syn_ready rises exactly NUM_NEURONS cycles later.
- **Accumulation latency:** an event accepted at edge T is committed to RAM at edge T+2 and is visible to a drain read from T+2 onward.
- **Tick-to-output:** first m_cur_valid for ID 0 no later than 4 cycles after the tick edge.
- **Drain rate:** sustained 1 entry per 2 cycles with m_cur_ready held high (read cycle plus present cycle).
- **Output stability:** m_cur_neuron_id and m_cur_value are registered and stable while m_cur_valid && !m_cur_ready.
- **Return to ACCUM:** the cycle after the last drain handshake, busy = 0 and s_syn_ready = 1.

## Test plan
- **Reset and empty drain:** release reset. Required: s_syn_ready low for 64 cycles, then high. Tick with no events. Required: 64 outputs, IDs 0..63 in order, all values 0.
- **Mixed accumulation:** send ID 5 exc w=10, then ID 5 inh w=3 back-to-back (forwarding path), then ID 7 exc w=255, then tick. Required: ID 5 = 7, ID 7 = 255, all others 0.
- **Positive saturation:** send 200 exc w=255 events to ID 1, then tick. Required: ID 1 = 32767, sat_count = 72. Also send 200 inh w=255 events to ID 2. Required: ID 2 = -32768.
- **Backpressure and clear:** toggle m_cur_ready pseudo-randomly during a drain. Required: each ID emitted exactly once, values stable while stalled. A second tick with no events yields all zeros.
- **Tick corner cases:** a tick coincident with an accepted event to ID 3 w=4 drains ID 3 = 4. A tick asserted during DRAIN sets tick_overrun = 1 and no second drain starts.
- **Reset mid-drain:** assert rst_n low at ID 20 of a drain. Required: m_cur_valid = 0 immediately, CLEAR reruns, and the next drain is all zeros.

Source files
------------

// File: rtl/synaptic_accumulator.sv
// rtl/synaptic_accumulator.sv - per-neuron signed synaptic current accumulator with timestep drain
//
// Accumulates weighted synaptic events into a per-neuron signed current buffer.
// On each timestep tick every entry is drained in neuron-ID order and cleared.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   s_syn_valid/ready           synaptic event handshake
//   s_syn_dest_id               target neuron
//   s_syn_weight, s_syn_exc_inh unsigned weight; 1 = add, 0 = subtract
//   timestep_tick               single-cycle pulse ending the current timestep
//   m_cur_valid/ready           drained-current handshake
//   m_cur_neuron_id, m_cur_value drained neuron ID and signed current
//   busy                        high whenever not accumulating
//   sat_count                   saturating count of clamped accumulations
//   tick_overrun                sticky flag: a tick arrived while not accumulating

module synaptic_accumulator #(
    parameter int NUM_NEURONS     = 64,
    parameter int NEURON_ID_WIDTH = 6,
    parameter int WEIGHT_WIDTH    = 8,
    parameter int ACC_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_syn_valid,
    input  logic [NEURON_ID_WIDTH-1:0] s_syn_dest_id,
    input  logic [WEIGHT_WIDTH-1:0]    s_syn_weight,
    input  logic                       s_syn_exc_inh,
    output logic                       s_syn_ready,
    input  logic                       timestep_tick,
    output logic                       m_cur_valid,
    output logic [NEURON_ID_WIDTH-1:0] m_cur_neuron_id,
    output logic [ACC_WIDTH-1:0]       m_cur_value,
    input  logic                       m_cur_ready,
    output logic                       busy,
    output logic [15:0]                sat_count,
    output logic                       tick_overrun
);

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_ACCUM,
        ST_DRAIN_WAIT,
        ST_DRAIN
    } state_t;

    localparam logic [NEURON_ID_WIDTH-1:0] LAST_ID = NEURON_ID_WIDTH'(NUM_NEURONS - 1);
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic [ACC_WIDTH-1:0] acc_mem [NUM_NEURONS];

    state_t state, state_next;

    // Shared index: clear address in CLEAR, drain address in DRAIN.
    logic [NEURON_ID_WIDTH-1:0] idx;
    // Drain sub-phase: 0 = read entry, 1 = entry presented on m_cur_*.
    logic                       drain_present;
    logic                       tick_pending;

    // RMW stage 1: accepted event, entry read at the next edge.
    logic                       s1_valid;
    logic [NEURON_ID_WIDTH-1:0] s1_id;
    logic [WEIGHT_WIDTH-1:0]    s1_weight;
    logic                       s1_exc;

    // RMW stage 2: entry value in hand, sum written back at the next edge.
    logic                       s2_valid;
    logic [NEURON_ID_WIDTH-1:0] s2_id;
    logic [WEIGHT_WIDTH-1:0]    s2_weight;
    logic                       s2_exc;
    logic [ACC_WIDTH-1:0]       s2_data;

    logic [ACC_WIDTH:0]         s2_ext;
    logic [ACC_WIDTH:0]         s2_wext;
    logic [ACC_WIDTH:0]         s2_sum;
    logic                       s2_sat;
    logic [ACC_WIDTH-1:0]       s2_result;

    logic accept;
    logic drain_hs;
    logic clear_done;
    logic drain_done;

    assign s_syn_ready = (state == ST_ACCUM) && !tick_pending;
    assign busy        = (state != ST_ACCUM);
    assign accept      = s_syn_valid && s_syn_ready;
    assign drain_hs    = (state == ST_DRAIN) && m_cur_valid && m_cur_ready;
    assign clear_done  = (state == ST_CLEAR) && (idx == LAST_ID);
    assign drain_done  = drain_hs && (idx == LAST_ID);

    // One extra bit of headroom; overflow shows up as the top two bits differing,
    // and the top bit then gives the direction of the clamp.
    always_comb begin
        s2_ext    = {s2_data[ACC_WIDTH-1], s2_data};
        s2_wext   = {{(ACC_WIDTH+1-WEIGHT_WIDTH){1'b0}}, s2_weight};
        s2_sum    = s2_exc ? (s2_ext + s2_wext) : (s2_ext - s2_wext);
        s2_sat    = (s2_sum[ACC_WIDTH] != s2_sum[ACC_WIDTH-1]);
        s2_result = s2_sum[ACC_WIDTH-1:0];
        if (s2_sat) begin
            s2_result = s2_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_CLEAR:      if (clear_done)    state_next = ST_ACCUM;
            ST_ACCUM:      if (timestep_tick) state_next = ST_DRAIN_WAIT;
            // Stage 2 commits on the same edge we leave, so the first drain
            // read (one edge later) already sees the final value.
            ST_DRAIN_WAIT: if (!s1_valid)     state_next = ST_DRAIN;
            ST_DRAIN:      if (drain_done)    state_next = ST_ACCUM;
            default:                          state_next = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx             <= '0;
            drain_present   <= 1'b0;
            tick_pending    <= 1'b0;
            tick_overrun    <= 1'b0;
            sat_count       <= '0;
            s1_valid        <= 1'b0;
            s1_id           <= '0;
            s1_weight       <= '0;
            s1_exc          <= 1'b0;
            s2_valid        <= 1'b0;
            s2_id           <= '0;
            s2_weight       <= '0;
            s2_exc          <= 1'b0;
            s2_data         <= '0;
            m_cur_valid     <= 1'b0;
            m_cur_neuron_id <= '0;
            m_cur_value     <= '0;
        end else begin
            s1_valid  <= accept;
            s1_id     <= s_syn_dest_id;
            s1_weight <= s_syn_weight;
            s1_exc    <= s_syn_exc_inh;

            // Stage 2 writes back on this same edge, so a back-to-back hit
            // must take the fresh sum instead of the stale RAM word.
            s2_valid  <= s1_valid;
            s2_id     <= s1_id;
            s2_weight <= s1_weight;
            s2_exc    <= s1_exc;
            s2_data   <= (s2_valid && (s2_id == s1_id)) ? s2_result : acc_mem[s1_id];

            if (s2_valid && s2_sat && (sat_count != 16'hFFFF)) begin
                sat_count <= sat_count + 16'd1;
            end

            if (timestep_tick) begin
                if (state == ST_ACCUM) begin
                    tick_pending <= 1'b1;
                end else begin
                    tick_overrun <= 1'b1;
                end
            end

            case (state)
                ST_CLEAR: begin
                    idx <= clear_done ? '0 : idx + 1'b1;
                end
                ST_DRAIN_WAIT: begin
                    idx           <= '0;
                    drain_present <= 1'b0;
                end
                ST_DRAIN: begin
                    if (!drain_present) begin
                        m_cur_valid     <= 1'b1;
                        m_cur_neuron_id <= idx;
                        m_cur_value     <= acc_mem[idx];
                        drain_present   <= 1'b1;
                    end else if (m_cur_ready) begin
                        m_cur_valid   <= 1'b0;
                        drain_present <= 1'b0;
                        idx           <= drain_done ? '0 : idx + 1'b1;
                        if (drain_done) begin
                            tick_pending <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Single write port: clear, RMW commit and post-drain zeroing never overlap.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            acc_mem[idx] <= '0;
        end else if (s2_valid) begin
            acc_mem[s2_id] <= s2_result;
        end else if (drain_hs) begin
            acc_mem[idx] <= '0;
        end
    end

endmodule

// File: tb/tb_synaptic_accumulator.sv
// tb/tb_synaptic_accumulator.sv - directed self-checking bench for synaptic_accumulator

module tb_synaptic_accumulator;

    logic        clk;
    logic        rst_n;
    logic        s_syn_valid;
    logic [5:0]  s_syn_dest_id;
    logic [7:0]  s_syn_weight;
    logic        s_syn_exc_inh;
    logic        s_syn_ready;
    logic        timestep_tick;
    logic        m_cur_valid;
    logic [5:0]  m_cur_neuron_id;
    logic [15:0] m_cur_value;
    logic        m_cur_ready;
    logic        busy;
    logic [15:0] sat_count;
    logic        tick_overrun;

    int checks;
    int errors;
    int exp_vals [64];

    synaptic_accumulator dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_syn_valid     (s_syn_valid),
        .s_syn_dest_id   (s_syn_dest_id),
        .s_syn_weight    (s_syn_weight),
        .s_syn_exc_inh   (s_syn_exc_inh),
        .s_syn_ready     (s_syn_ready),
        .timestep_tick   (timestep_tick),
        .m_cur_valid     (m_cur_valid),
        .m_cur_neuron_id (m_cur_neuron_id),
        .m_cur_value     (m_cur_value),
        .m_cur_ready     (m_cur_ready),
        .busy            (busy),
        .sat_count       (sat_count),
        .tick_overrun    (tick_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 64; i++) exp_vals[i] = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_syn_ready"}, s_syn_ready, 0);
        check({tag, "_cur_valid"}, m_cur_valid, 0);
        check({tag, "_cur_id"}, m_cur_neuron_id, 0);
        check({tag, "_cur_value"}, m_cur_value, 0);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_sat_count"}, sat_count, 0);
        check({tag, "_overrun"}, tick_overrun, 0);
    endtask

    // Called at a negedge right after rst_n is released.
    task automatic wait_clear(input string tag);
        int cnt;
        cnt = 0;
        while (!s_syn_ready && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check(tag, cnt, 64);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic send(input int id, input int w, input bit exc);
        s_syn_valid   = 1'b1;
        s_syn_dest_id = 6'(id);
        s_syn_weight  = 8'(w);
        s_syn_exc_inh = exc;
        check("send_ready", s_syn_ready, 1);
        @(negedge clk);
        s_syn_valid = 1'b0;
    endtask

    // Collects one drain, checking order, values against exp_vals, stability under
    // backpressure and timing. abort_id >= 0 asserts reset when that ID is presented.
    task automatic run_drain(input bit do_tick, input bit rand_ready, input bit inject_tick, input int abort_id);
        int n, cyc, lat, first_cyc, last_cyc;
        bit prev_stall, aborted, injected;
        logic [5:0]  prev_id;
        logic [15:0] prev_val;
        n = 0; cyc = 0; lat = -1; first_cyc = 0; last_cyc = 0;
        prev_stall = 0; aborted = 0; injected = 0;
        prev_id = '0; prev_val = '0;
        if (do_tick) begin
            timestep_tick = 1'b1;
            @(negedge clk);
            timestep_tick = 1'b0;
        end
        while (n < 64 && cyc < 3000 && !aborted) begin
            m_cur_ready   = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            timestep_tick = 1'b0;
            if (inject_tick && n == 10 && !injected) begin
                timestep_tick = 1'b1;
                injected = 1;
            end
            if (prev_stall) begin
                check("stall_valid_held", m_cur_valid, 1);
                check("stall_id_stable", m_cur_neuron_id, prev_id);
                check("stall_value_stable", $signed(m_cur_value), $signed(prev_val));
            end
            prev_stall = 0;
            if (m_cur_valid) begin
                if (lat < 0) lat = cyc;
                if (abort_id >= 0 && int'(m_cur_neuron_id) == abort_id) begin
                    rst_n = 1'b0;
                    #1;
                    check("abort_valid_low", m_cur_valid, 0);
                    aborted = 1;
                end else if (m_cur_ready) begin
                    check("drain_id", m_cur_neuron_id, n);
                    check("drain_value", $signed(m_cur_value), exp_vals[n]);
                    if (n == 0) first_cyc = cyc;
                    last_cyc = cyc;
                    n++;
                end else begin
                    prev_stall = 1;
                    prev_id    = m_cur_neuron_id;
                    prev_val   = m_cur_value;
                end
            end
            if (!aborted) begin
                @(negedge clk);
                cyc++;
            end
        end
        timestep_tick = 1'b0;
        m_cur_ready   = 1'b1;
        if (abort_id >= 0) begin
            check("abort_reached", aborted, 1);
        end else begin
            check("drain_count", n, 64);
            check("tick_latency_ok", (lat >= 0 && lat <= 4), 1);
            if (!rand_ready) check("drain_rate", last_cyc - first_cyc, 126);
            check("post_drain_busy", busy, 0);
            check("post_drain_ready", s_syn_ready, 1);
        end
    endtask

    initial begin
        int any_valid;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        s_syn_valid = 1'b0;
        s_syn_dest_id = '0;
        s_syn_weight = '0;
        s_syn_exc_inh = 1'b0;
        timestep_tick = 1'b0;
        m_cur_ready = 1'b1;
        clear_exp();

        // Reset and empty drain
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        rst_n = 1'b1;
        wait_clear("clear_cycles");
        run_drain(1, 0, 0, -1);

        // Mixed accumulation with same-ID forwarding
        send(5, 10, 1);
        send(5, 3, 0);
        send(7, 255, 1);
        exp_vals[5] = 7;
        exp_vals[7] = 255;
        run_drain(1, 0, 0, -1);
        clear_exp();

        // Positive saturation: 128*255 = 32640, events 129..200 clamp
        repeat (200) send(1, 255, 1);
        exp_vals[1] = 32767;
        run_drain(1, 0, 0, -1);
        check("sat_count_pos", sat_count, 72);
        clear_exp();

        // Negative saturation under random backpressure
        repeat (200) send(2, 255, 0);
        exp_vals[2] = -32768;
        run_drain(1, 1, 0, -1);
        check("sat_count_neg", sat_count, 144);
        clear_exp();

        // Buffer cleared by the previous drain
        run_drain(1, 1, 0, -1);

        // Event coincident with tick belongs to this timestep; tick during drain dropped
        check("overrun_before", tick_overrun, 0);
        s_syn_valid   = 1'b1;
        s_syn_dest_id = 6'd3;
        s_syn_weight  = 8'd4;
        s_syn_exc_inh = 1'b1;
        timestep_tick = 1'b1;
        check("coincident_ready", s_syn_ready, 1);
        @(negedge clk);
        s_syn_valid   = 1'b0;
        timestep_tick = 1'b0;
        exp_vals[3] = 4;
        run_drain(0, 0, 1, -1);
        clear_exp();
        check("overrun_set", tick_overrun, 1);
        any_valid = 0;
        repeat (20) begin
            @(negedge clk);
            if (m_cur_valid || busy) any_valid = 1;
        end
        check("no_second_drain", any_valid, 0);

        // Reset mid-drain discards accumulated data
        send(30, 9, 1);
        exp_vals[30] = 9;
        run_drain(1, 0, 0, 20);
        repeat (2) @(negedge clk);
        check_reset_values("rst_mid");
        rst_n = 1'b1;
        clear_exp();
        wait_clear("reclear_cycles");
        run_drain(1, 0, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
